// File: rtl/iob_ctls.sv
// Count leading or trailing symbols of a word (MODE=1 leading, MODE=0 trailing).
// SYMBOL selects whether zeros (0) or ones (1) are counted; the result is W for a uniform word.
module iob_ctls #(
    parameter int W      = 21,
    parameter int MODE   = 0,
    parameter bit SYMBOL = 1'b0,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0] scan;
    logic         found;

    // Walk the word one bit per step so no variable bit-select is needed
    always_comb begin
        count_o = CNT_W'(W);
        found   = 1'b0;
        scan    = SYMBOL ? data_i : ~data_i;
        for (int i = 0; i < W; i++) begin
            if (MODE == 1) begin
                if (!found && !scan[W-1]) begin
                    count_o = CNT_W'(i);
                    found   = 1'b1;
                end
                scan = scan << 1;
            end else begin
                if (!found && !scan[0]) begin
                    count_o = CNT_W'(i);
                    found   = 1'b1;
                end
                scan = scan >> 1;
            end
        end
    end

endmodule

// File: rtl/iob_lz_norm.sv
// Two-stage leading-zero normalizer: S1 captures the word and its leading-zero count,
// S2 left-shifts the word so its MSB is set, with valid/ready flow control.
module iob_lz_norm #(
    parameter int W      = 21,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_n_i,
    input  logic [W-1:0]     data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic             v1;
    logic [W-1:0]     s1_data;
    logic [CNT_W-1:0] s1_lz;
    logic [CNT_W-1:0] lz_in;
    logic             v2;
    logic             s1_en;
    logic             s2_en;

    iob_ctls #(
        .W      (W),
        .MODE   (1),
        .SYMBOL (1'b0)
    ) u_ctls (
        .data_i  (data_i),
        .count_o (lz_in)
    );

    // S2 may load when empty or being drained; S1 may load when empty or S2 takes its word
    assign s2_en   = cke_i & (~v2 | ready_i);
    assign s1_en   = cke_i & (~v1 | s2_en);
    assign ready_o = s1_en;
    assign valid_o = v2;

    // A shift by exactly W is defined in SV to yield zero, which is the all-zero result we want
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v1      <= 1'b0;
            s1_data <= '0;
            s1_lz   <= '0;
            v2      <= 1'b0;
            data_o  <= '0;
            count_o <= '0;
            zero_o  <= 1'b0;
        end else begin
            if (s2_en) begin
                v2      <= v1;
                data_o  <= s1_data << s1_lz;
                count_o <= s1_lz;
                zero_o  <= (s1_lz == CNT_W'(W));
            end
            if (s1_en) begin
                v1      <= valid_i;
                s1_data <= data_i;
                s1_lz   <= lz_in;
            end
        end
    end

endmodule

// File: tb/tb_iob_lz_norm.sv
// Directed bench for iob_lz_norm (W=21): hand-computed vectors checked through a small
// expected-output queue, plus explicit latency, backpressure, clock-enable and reset checks.
module tb_iob_lz_norm;

    localparam int W     = 21;
    localparam int CNT_W = $clog2(W) + 1;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [CNT_W-1:0] count;
        logic             zero;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             cke_i;
    logic             rst_n_i;
    logic [W-1:0]     data_i;
    logic             valid_i;
    logic             ready_o;
    logic [W-1:0]     data_o;
    logic [CNT_W-1:0] count_o;
    logic             zero_o;
    logic             valid_o;
    logic             ready_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t exp_cur;
    logic last_in;
    logic last_ready;

    exp_t vec[5];
    int   k;

    iob_lz_norm #(.W(W)) dut (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .count_o (count_o),
        .zero_o  (zero_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: settle inputs, score any output transfer, log any input transfer, then clock
    task automatic cycle();
        exp_t e;
        #1;
        last_ready = ready_o;
        last_in    = valid_i && ready_o && rst_n_i;
        if (rst_n_i && valid_o && ready_i && cke_i) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_output", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("sb_data", 32'(data_o), 32'(e.data));
                check_output("sb_count", 32'(count_o), 32'(e.count));
                check_output("sb_zero", 32'(zero_o), 32'(e.zero));
            end
        end
        if (last_in) exp_q.push_back(exp_cur);
        @(posedge clk_i);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic apply_stimulus(input exp_t v_in, input logic [W-1:0] d);
        int budget;
        valid_i = 1'b1;
        data_i  = d;
        exp_cur = v_in;
        budget  = 0;
        do begin
            cycle();
            budget++;
        end while (!last_in && budget < 20);
        if (!last_in) check_output("accept_timeout", 32'(budget), 32'd0);
    endtask

    task automatic drain();
        int budget;
        valid_i = 1'b0;
        ready_i = 1'b1;
        budget  = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cycle();
            budget++;
        end
        check_output("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input int c, input logic z);
        mk.data  = d;
        mk.count = CNT_W'(c);
        mk.zero  = z;
    endfunction

    initial begin
        cke_i   = 1'b1;
        rst_n_i = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        exp_cur = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        #1;
        check_output("rst_valid", 32'(valid_o), 32'd0);
        check_output("rst_data", 32'(data_o), 32'd0);
        check_output("rst_count", 32'(count_o), 32'd0);
        check_output("rst_zero", 32'(zero_o), 32'd0);
        check_output("rst_ready", 32'(ready_o), 32'd1);

        // Lowest bit only: latency check, then the queue scores it again
        apply_stimulus(mk(21'h100000, 20, 1'b0), 21'h000001);
        valid_i = 1'b0;
        check_output("lat_after_n", 32'(valid_o), 32'd0);
        cycle();
        check_output("lat_after_n1", 32'(valid_o), 32'd1);
        check_output("lat_data", 32'(data_o), 32'h100000);
        check_output("lat_count", 32'(count_o), 32'd20);
        check_output("lat_zero", 32'(zero_o), 32'd0);
        drain();

        apply_stimulus(mk(21'h000000, 21, 1'b1), 21'h000000);
        apply_stimulus(mk(21'h180000, 0, 1'b0), 21'h180000);
        apply_stimulus(mk(21'h1E6000, 13, 1'b0), 21'h0000F3);
        drain();

        // Back-to-back stream: outputs must leave on consecutive cycles
        apply_stimulus(mk(21'h100000, 18, 1'b0), 21'h000004);
        apply_stimulus(mk(21'h100000, 8, 1'b0), 21'h001000);
        apply_stimulus(mk(21'h100000, 2, 1'b0), 21'h040000);
        valid_i = 1'b0;
        check_output("stream_pending2", 32'(exp_q.size()), 32'd2);
        cycle();
        check_output("stream_pending1", 32'(exp_q.size()), 32'd1);
        cycle();
        check_output("stream_pending0", 32'(exp_q.size()), 32'd0);

        vec[0] = mk(21'h180000, 19, 1'b0);
        vec[1] = mk(21'h140000, 13, 1'b0);
        vec[2] = mk(21'h123450, 4, 1'b0);
        vec[3] = mk(21'h1FFFFF, 0, 1'b0);
        vec[4] = mk(21'h1FFC00, 10, 1'b0);

        // Backpressure: two words buffer, then ready_o drops and the output holds
        ready_i = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            valid_i = 1'b1;
            data_i  = (k == 0) ? 21'h000003 : (k == 1) ? 21'h0000A0 : 21'h012345;
            exp_cur = vec[k];
            cycle();
            if (last_in) k++;
            if (cyc >= 2) begin
                check_output("stall_ready", 32'(last_ready), 32'd0);
                check_output("stall_accepted", 32'(k), 32'd2);
                check_output("stall_valid", 32'(valid_o), 32'd1);
                check_output("stall_data", 32'(data_o), 32'h180000);
            end
        end
        ready_i = 1'b1;
        apply_stimulus(vec[2], 21'h012345);
        apply_stimulus(vec[3], 21'h1FFFFF);
        apply_stimulus(vec[4], 21'h0007FF);
        drain();

        // Clock enable low: nothing moves and ready_o is forced low
        ready_i = 1'b0;
        apply_stimulus(vec[0], 21'h000003);
        apply_stimulus(vec[1], 21'h0000A0);
        ready_i = 1'b1;
        cke_i   = 1'b0;
        valid_i = 1'b1;
        data_i  = 21'h012345;
        exp_cur = vec[2];
        for (int cyc = 0; cyc < 2; cyc++) begin
            cycle();
            check_output("cke_ready", 32'(last_ready), 32'd0);
            check_output("cke_valid", 32'(valid_o), 32'd1);
            check_output("cke_data", 32'(data_o), 32'h180000);
            check_output("cke_count", 32'(count_o), 32'd19);
        end
        cke_i = 1'b1;
        apply_stimulus(vec[2], 21'h012345);
        apply_stimulus(vec[3], 21'h1FFFFF);
        apply_stimulus(vec[4], 21'h0007FF);
        drain();

        // Reset with both stages full: buffered words must vanish
        ready_i = 1'b0;
        apply_stimulus(vec[3], 21'h1FFFFF);
        apply_stimulus(vec[4], 21'h0007FF);
        valid_i = 1'b0;
        check_output("prerst_valid", 32'(valid_o), 32'd1);
        rst_n_i = 1'b0;
        cycle();
        rst_n_i = 1'b1;
        exp_q.delete();
        check_output("midrst_valid", 32'(valid_o), 32'd0);
        check_output("midrst_count", 32'(count_o), 32'd0);
        check_output("midrst_data", 32'(data_o), 32'd0);
        check_output("midrst_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        apply_stimulus(mk(21'h100000, 18, 1'b0), 21'h000004);
        drain();
        for (int cyc = 0; cyc < 3; cyc++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_lz_norm.md
Name: iob_lz_norm

Overview:
- Pipelined leading-zero normalizer that sits directly downstream of a leading-zero counter.
- Counts the leading zeros of each input word, then left-shifts the word so its MSB is 1.
- Outputs the normalized word, the shift count and a zero flag.
- Feeds float/fixed-point packing logic over a valid/ready stream; 2-cycle latency, full throughput.

Parameters:
- W, 21, data width in bits (W >= 2).
- CNT_W, derived localparam = $clog2(W)+1, width of the count (range 0..W); not overridable.

Ports:
- clk_i  input  1  system clock, rising edge.
- cke_i  input  1  clock enable; when 0 all state holds.
- rst_n_i  input  1  synchronous active-low reset.
- data_i  input  W  word to normalize.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_o  output  W  normalized word (data_i << count).
- count_o  output  CNT_W  number of leading zeros of data_i (W when data_i == 0).
- zero_o  output  1  input word was all zeros.
- valid_o  output  1  data_o/count_o/zero_o valid.
- ready_i  input  1  downstream accepts the output this cycle.

Behaviour:
- Reset is synchronous: sampled on the rising edge of clk_i with rst_n_i == 0, regardless of cke_i. Stage-1 and stage-2 valid, data, count and zero registers all clear to 0. After reset valid_o=0, data_o=0, count_o=0, zero_o=0.
- Stage 1 (S1):
  - On accept, registers data_i, plus lz = leading-zero count of data_i from the existing iob_ctls instance (MODE=1, SYMBOL=0, W).
  - Sets v1.
- Stage 2 (S2):
  - On advance, registers data_o = S1.data << S1.lz, count_o = S1.lz, zero_o = (S1.lz == W).
  - Sets v2. valid_o = v2.
- Shift rule: the shift amount is CNT_W bits wide. lz == W yields data_o = 0, with no out-of-range shift artefacts. Bits shifted out are discarded; zeros fill from the LSB.
- Handshake enables:
  - s2_en = cke_i & (~v2 | ready_i)
  - s1_en = cke_i & (~v1 | s2_en)
  - ready_o = s1_en (combinational); ready_o = 0 whenever cke_i = 0.
- Transfers:
  - Input transfer when valid_i & ready_o.
  - Output transfer when valid_o & ready_i & cke_i.
- Register updates:
  - When s2_en, v2 <= v1 and S2 loads from S1.
  - When s1_en, v1 <= valid_i and S1 loads data_i.
- Latency: an input accepted at edge N appears on valid_o after edge N+1. This gives 1 cycle in S1 and output valid in the cycle after the second edge.
- Throughput: one word per cycle while ready_i = 1.
- Backpressure: while valid_o & ~ready_i, data_o/count_o/zero_o/valid_o stay stable. S1 can still fill, so up to 2 words are buffered; ready_o then drops to 0. No word is dropped or duplicated; order is preserved.
- Simultaneous events: output consume and new input in the same cycle both occur; the pipeline shifts by one.
- Reset mid-operation: all in-flight words are discarded; valid_o = 0 after the reset edge, and ready_o = 1 on the first cycle after reset if cke_i = 1.
- Payload registers of an invalid stage may hold stale values; only valid qualifies them. Reset still clears them to 0.
- Protocol: valid_i may be asserted without waiting for ready_o. Upstream must hold data_i until transfer. The block does not check this.

Decomposition:
- No shared package; CNT_W is a local derived constant. The block reuses no typedefs.
- Leading-zero count comes from the existing iob_ctls module, instantiated in the S1 combinational path.
- The barrel shifter and the two pipeline stages are inline. A separate stage module is not warranted at this size.

Test Plan (W=21):
- data_i=21'h000001, ready_i=1 -> 2 cycles later valid_o=1, data_o=21'h100000, count_o=20, zero_o=0.
- data_i=21'h000000 -> data_o=0, count_o=21, zero_o=1.
- data_i=21'h180000 (MSB set) -> data_o=21'h180000, count_o=0. Then data_i=21'h0000F3 -> data_o=21'h1E6000, count_o=13.
- Stream 21'h000004, 21'h001000, 21'h040000 on consecutive cycles, ready_i=1 -> outputs on 3 consecutive cycles with count_o=18, 8, 2.
- Stream of 5 words with ready_i=0 for 4 cycles, then 1:
  - ready_o drops after 2 accepted words; valid_o and data_o stay stable while stalled.
  - All 5 words are delivered in order with no loss or duplication.
  - Repeat with cke_i=0 for 2 cycles: state frozen, ready_o=0.
- rst_n_i=0 for 1 cycle with both stages valid -> valid_o=0 and count_o=0 next cycle; the previously buffered words never appear; the next input flows normally.
